// File: rtl/cnn_run_sequencer.sv
// cnn_run_sequencer: run controller that starts CNN, streams ifmap/filter words into its buffers and drains results (RUN_SEQ_TIMEOUT_EN adds a RUN watchdog)
module cnn_run_sequencer #(
  parameter int IFMAP_BUFFER_WIDTH  = 18,
  parameter int FILTER_BUFFER_WIDTH = 16,
  parameter int RESULT_BUFFER_WIDTH = 16,
  parameter int STRIDE_WIDTH        = 5,
  parameter int FILTER_SIZE_WIDTH   = 5,
  parameter int CNT_WIDTH           = 8,
  parameter int TIMEOUT_WIDTH       = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           run_go,
  input  logic [STRIDE_WIDTH-1:0]        cfg_stride,
  input  logic [FILTER_SIZE_WIDTH-1:0]   cfg_filter_size,
  input  logic [CNT_WIDTH-1:0]           cfg_if_words,
  input  logic [CNT_WIDTH-1:0]           cfg_flt_words,
  input  logic [CNT_WIDTH-1:0]           cfg_res_words,
  output logic                           run_busy,
  output logic                           run_done,
  output logic                           run_error,
  input  logic [IFMAP_BUFFER_WIDTH-1:0]  if_src_data,
  input  logic                           if_src_valid,
  output logic                           if_src_ready,
  input  logic [FILTER_BUFFER_WIDTH-1:0] flt_src_data,
  input  logic                           flt_src_valid,
  output logic                           flt_src_ready,
  output logic [RESULT_BUFFER_WIDTH-1:0] res_data,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic                           start,
  output logic [STRIDE_WIDTH-1:0]        stride,
  output logic [FILTER_SIZE_WIDTH-1:0]   filter_size,
  output logic [IFMAP_BUFFER_WIDTH-1:0]  IFmap_buffer_in,
  output logic                           IFmap_buffer_write_enable,
  input  logic                           IFmap_buffer_ready,
  output logic [FILTER_BUFFER_WIDTH-1:0] filter_buffer_in,
  output logic                           filter_buffer_write_enable,
  input  logic                           filter_buffer_ready,
  output logic                           result_buffer_read_enable,
  input  logic [RESULT_BUFFER_WIDTH-1:0] result_buffer_out,
  input  logic                           result_buffer_valid,
  input  logic                           result_buffer_empty
);
  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;
  state_t state;
  logic [CNT_WIDTH-1:0] if_target, flt_target, res_target, if_cnt, flt_cnt, res_cnt;
  logic run, if_take, if_put, flt_take, flt_put, res_take, res_put, lanes_done, wd_fire;
  logic unused_status;
  assign unused_status = result_buffer_empty;
  assign run = state == RUN;
  assign if_src_ready = run && !IFmap_buffer_write_enable && if_cnt < if_target;
  assign flt_src_ready = run && !filter_buffer_write_enable && flt_cnt < flt_target;
  assign result_buffer_read_enable = run && !res_valid && res_cnt < res_target;
  assign if_take = if_src_ready && if_src_valid;
  assign if_put = IFmap_buffer_write_enable && IFmap_buffer_ready;
  assign flt_take = flt_src_ready && flt_src_valid;
  assign flt_put = filter_buffer_write_enable && filter_buffer_ready;
  assign res_take = result_buffer_read_enable && result_buffer_valid;
  assign res_put = res_valid && res_ready;
  assign lanes_done = if_cnt == if_target && flt_cnt == flt_target && res_cnt == res_target &&
                      !IFmap_buffer_write_enable && !filter_buffer_write_enable && !res_valid;
`ifdef RUN_SEQ_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wd;
  assign wd_fire = &wd;
  always_ff @(posedge clk)
    wd <= (reset || !run || if_take || if_put || flt_take || flt_put || res_take || res_put) ? '0 : wd + 1'b1;
`else
  logic [TIMEOUT_WIDTH-1:0] unused_wd;
  assign unused_wd = '0;
  assign wd_fire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      {start, run_busy, run_done, run_error} <= '0;
      {IFmap_buffer_write_enable, filter_buffer_write_enable, res_valid} <= '0;
      {IFmap_buffer_in, filter_buffer_in, res_data, stride, filter_size} <= '0;
      {if_target, flt_target, res_target, if_cnt, flt_cnt, res_cnt} <= '0;
    end else begin
      start <= 1'b0;
      run_done <= 1'b0;
      run_error <= 1'b0;
      if (if_put) begin
        IFmap_buffer_write_enable <= 1'b0;
        if_cnt <= if_cnt + 1'b1;
      end
      if (if_take) begin
        IFmap_buffer_in <= if_src_data;
        IFmap_buffer_write_enable <= 1'b1;
      end
      if (flt_put) begin
        filter_buffer_write_enable <= 1'b0;
        flt_cnt <= flt_cnt + 1'b1;
      end
      if (flt_take) begin
        filter_buffer_in <= flt_src_data;
        filter_buffer_write_enable <= 1'b1;
      end
      if (res_put) res_valid <= 1'b0;
      if (res_take) begin
        res_data <= result_buffer_out;
        res_valid <= 1'b1;
        res_cnt <= res_cnt + 1'b1;
      end
      case (state)
        IDLE: if (run_go) begin
          {stride, filter_size} <= {cfg_stride, cfg_filter_size};
          {if_target, flt_target, res_target} <= {cfg_if_words, cfg_flt_words, cfg_res_words};
          {if_cnt, flt_cnt, res_cnt} <= '0;
          start <= 1'b1;
          run_busy <= 1'b1;
          state <= START;
        end
        START: state <= RUN;
        RUN: if (wd_fire) begin
          {IFmap_buffer_write_enable, filter_buffer_write_enable, res_valid} <= '0;
          {run_done, run_error} <= 2'b11;
          state <= DONE;
        end else if (lanes_done) begin
          run_done <= 1'b1;
          state <= DONE;
        end
        default: begin
          run_busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_run_sequencer.sv
// tb_cnn_run_sequencer: randomized scoreboard bench for cnn_run_sequencer
module tb_cnn_run_sequencer;
  localparam int IW = 18, FW = 16, RW = 16, SW = 5, FSW = 5, CW = 8, TW = 12;
  logic clk = 0, reset, run_go;
  logic [SW-1:0] cfg_stride, stride;
  logic [FSW-1:0] cfg_filter_size, filter_size;
  logic [CW-1:0] cfg_if_words, cfg_flt_words, cfg_res_words;
  logic run_busy, run_done, run_error, start;
  logic [IW-1:0] if_src_data, IFmap_buffer_in;
  logic [FW-1:0] flt_src_data, filter_buffer_in;
  logic [RW-1:0] res_data, result_buffer_out;
  logic if_src_valid, if_src_ready, flt_src_valid, flt_src_ready, res_valid, res_ready;
  logic IFmap_buffer_write_enable, IFmap_buffer_ready, filter_buffer_write_enable, filter_buffer_ready;
  logic result_buffer_read_enable, result_buffer_valid, result_buffer_empty;

  cnn_run_sequencer #(
    .IFMAP_BUFFER_WIDTH(IW), .FILTER_BUFFER_WIDTH(FW), .RESULT_BUFFER_WIDTH(RW),
    .STRIDE_WIDTH(SW), .FILTER_SIZE_WIDTH(FSW), .CNT_WIDTH(CW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .run_go(run_go),
    .cfg_stride(cfg_stride), .cfg_filter_size(cfg_filter_size),
    .cfg_if_words(cfg_if_words), .cfg_flt_words(cfg_flt_words), .cfg_res_words(cfg_res_words),
    .run_busy(run_busy), .run_done(run_done), .run_error(run_error),
    .if_src_data(if_src_data), .if_src_valid(if_src_valid), .if_src_ready(if_src_ready),
    .flt_src_data(flt_src_data), .flt_src_valid(flt_src_valid), .flt_src_ready(flt_src_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .start(start), .stride(stride), .filter_size(filter_size),
    .IFmap_buffer_in(IFmap_buffer_in), .IFmap_buffer_write_enable(IFmap_buffer_write_enable),
    .IFmap_buffer_ready(IFmap_buffer_ready),
    .filter_buffer_in(filter_buffer_in), .filter_buffer_write_enable(filter_buffer_write_enable),
    .filter_buffer_ready(filter_buffer_ready),
    .result_buffer_read_enable(result_buffer_read_enable), .result_buffer_out(result_buffer_out),
    .result_buffer_valid(result_buffer_valid), .result_buffer_empty(result_buffer_empty)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [IW-1:0] if_src_q[$], if_exp_q[$];
  logic [FW-1:0] flt_src_q[$], flt_exp_q[$];
  logic [RW-1:0] rbuf_q[$], res_exp_q[$];
  bit err_exp_q[$];
  int errors = 0, checks = 0;
  bit rnd_if = 0, rnd_flt = 0, rnd_res = 0, rnd_src = 0, flushing = 0, flt_stuck = 0;
  int if_stall = 0, res_stall = 0;
  int if_writes, flt_writes, res_got, starts, if_acc, flt_acc, done_seen = 0, done_cyc, go_cyc;
  int cur_if, cur_flt, cur_res;
  logic [SW-1:0] cur_stride;
  logic [FSW-1:0] cur_fs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // host sources: offer queued words, pop on handshake
  initial begin
    bit f;
    if_src_valid = 0;
    if_src_data = '0;
    forever begin
      @(negedge clk);
      f = if_src_valid && if_src_ready;
      @(posedge clk);
      #1;
      if (f && if_src_q.size() > 0) begin
        void'(if_src_q.pop_front());
        if_acc++;
      end
      if_src_valid = if_src_q.size() > 0 && (!rnd_src || $urandom_range(0, 2) != 0);
      if_src_data = if_src_q.size() > 0 ? if_src_q[0] : '0;
    end
  end
  initial begin
    bit f;
    flt_src_valid = 0;
    flt_src_data = '0;
    forever begin
      @(negedge clk);
      f = flt_src_valid && flt_src_ready;
      @(posedge clk);
      #1;
      if (f && flt_src_q.size() > 0) begin
        void'(flt_src_q.pop_front());
        flt_acc++;
      end
      flt_src_valid = flt_src_q.size() > 0 && (!rnd_src || $urandom_range(0, 2) != 0);
      flt_src_data = flt_src_q.size() > 0 ? flt_src_q[0] : '0;
    end
  end

  // buffer-side ready and host res_ready drivers
  initial begin
    IFmap_buffer_ready = 0;
    filter_buffer_ready = 0;
    res_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (if_stall > 0) begin
        if_stall--;
        IFmap_buffer_ready = 0;
      end else IFmap_buffer_ready = !rnd_if || $urandom_range(0, 1) == 1;
      filter_buffer_ready = !flt_stuck && (!rnd_flt || $urandom_range(0, 1) == 1);
      if (res_stall > 0) begin
        res_stall--;
        res_ready = 0;
      end else res_ready = !rnd_res || $urandom_range(0, 1) == 1;
    end
  end

  // result buffer model: presents the head of rbuf_q, pops on read
  initial begin
    bit f;
    result_buffer_valid = 0;
    result_buffer_out = '0;
    result_buffer_empty = 1;
    forever begin
      @(negedge clk);
      f = result_buffer_read_enable && result_buffer_valid;
      @(posedge clk);
      #1;
      if (f && rbuf_q.size() > 0) void'(rbuf_q.pop_front());
      result_buffer_empty = rbuf_q.size() == 0;
      result_buffer_valid = !result_buffer_empty && (!rnd_res || $urandom_range(0, 2) != 0);
      result_buffer_out = result_buffer_empty ? '0 : rbuf_q[0];
    end
  end

  // monitors: compare buffer writes and host results against the scoreboard queues
  initial begin
    bit pw, fw, rv;
    logic [IW-1:0] pd;
    logic [FW-1:0] fd;
    logic [RW-1:0] rd;
    {pw, fw, rv} = '0;
    forever begin
      @(negedge clk);
      if (!flushing && !run_error) begin
        if (pw) check("if_hold", {IFmap_buffer_write_enable, IFmap_buffer_in}, {1'b1, pd});
        if (fw) check("flt_hold", {filter_buffer_write_enable, filter_buffer_in}, {1'b1, fd});
        if (rv) check("res_hold", {res_valid, res_data}, {1'b1, rd});
      end
      if (!flushing) begin
        if (IFmap_buffer_write_enable && IFmap_buffer_ready) begin
          if_writes++;
          if (if_exp_q.size() == 0) check("if_write_count", if_writes, cur_if);
          else check("if_write_data", IFmap_buffer_in, if_exp_q.pop_front());
        end
        if (filter_buffer_write_enable && filter_buffer_ready) begin
          flt_writes++;
          if (flt_exp_q.size() == 0) check("flt_write_count", flt_writes, cur_flt);
          else check("flt_write_data", filter_buffer_in, flt_exp_q.pop_front());
        end
        if (res_valid) check("res_overrun_read_enable", result_buffer_read_enable, 0);
        if (res_valid && res_ready) begin
          res_got++;
          if (res_exp_q.size() == 0) check("res_count", res_got, cur_res);
          else check("res_data", res_data, res_exp_q.pop_front());
        end
        if (start) starts++;
        if (run_done) begin
          bit e;
          done_seen++;
          done_cyc = cyc;
          check("done_expected", err_exp_q.size(), 1);
          e = err_exp_q.size() > 0 ? err_exp_q.pop_front() : 1'b0;
          check("run_error", run_error, e);
          if (!e) begin
            check("if_writes", if_writes, cur_if);
            check("flt_writes", flt_writes, cur_flt);
            check("res_got", res_got, cur_res);
            check("src_accepted", {if_acc, flt_acc}, {cur_if, cur_flt});
            check("start_pulses", starts, 1);
            check("cfg_latched", {stride, filter_size}, {cur_stride, cur_fs});
          end
        end
      end
      pw = IFmap_buffer_write_enable && !IFmap_buffer_ready;
      pd = IFmap_buffer_in;
      fw = filter_buffer_write_enable && !filter_buffer_ready;
      fd = filter_buffer_in;
      rv = res_valid && !res_ready;
      rd = res_data;
    end
  end

  task automatic check_reset_outputs();
    check("reset_ctrl", {start, run_busy, run_done, run_error, IFmap_buffer_write_enable,
                         filter_buffer_write_enable, result_buffer_read_enable, if_src_ready,
                         flt_src_ready, res_valid}, 0);
    check("reset_data", {IFmap_buffer_in, filter_buffer_in, res_data, stride, filter_size}, 0);
  endtask

  task automatic flush();
    if_src_q.delete();
    flt_src_q.delete();
    rbuf_q.delete();
    if_exp_q.delete();
    flt_exp_q.delete();
    res_exp_q.delete();
    err_exp_q.delete();
  endtask

  // mode: 0 plain, 1 ifmap ready stall, 2 res_ready stall, 3 reset mid-run
  task automatic run(input int ni, input int nf, input int nr, input bit err, input int mode);
    int d0, t;
    {if_writes, flt_writes, res_got, starts, if_acc, flt_acc} = '0;
    {cur_if, cur_flt, cur_res} = {ni, nf, nr};
    cur_stride = SW'($urandom);
    cur_fs = FSW'($urandom);
    for (int i = 0; i < ni + 2; i++) begin
      logic [IW-1:0] w = IW'($urandom);
      if_src_q.push_back(w);
      if (i < ni) if_exp_q.push_back(w);
    end
    for (int i = 0; i < nf + 2; i++) begin
      logic [FW-1:0] w = FW'($urandom);
      flt_src_q.push_back(w);
      if (i < nf) flt_exp_q.push_back(w);
    end
    for (int i = 0; i < nr + 2; i++) begin
      logic [RW-1:0] w = RW'($urandom);
      rbuf_q.push_back(w);
      if (i < nr) res_exp_q.push_back(w);
    end
    err_exp_q.push_back(err);
    d0 = done_seen;
    {cfg_stride, cfg_filter_size} = {cur_stride, cur_fs};
    {cfg_if_words, cfg_flt_words, cfg_res_words} = {CW'(ni), CW'(nf), CW'(nr)};
    run_go = 1;
    go_cyc = cyc;
    step(1);
    run_go = 0;
    {cfg_stride, cfg_filter_size} = {SW'($urandom), FSW'($urandom)};
    {cfg_if_words, cfg_flt_words, cfg_res_words} = {CW'($urandom), CW'($urandom), CW'($urandom)};
    t = 0;
    if (mode == 0 && ni >= 4) begin
      step(3);
      run_go = 1;
      step(1);
      run_go = 0;
    end else if (mode == 1 || mode == 3) begin
      while (if_writes < 5 && t < 2000) begin
        step(1);
        t++;
      end
      check("wait_if_writes", if_writes >= 5, 1);
      if (mode == 1) if_stall = 30;
      else begin
        flushing = 1;
        reset = 1;
        step(1);
        check_reset_outputs();
        reset = 0;
        flush();
        step(1);
        flushing = 0;
        return;
      end
    end else if (mode == 2) begin
      while (res_got < 3 && t < 2000) begin
        step(1);
        t++;
      end
      check("wait_res_got", res_got >= 3, 1);
      res_stall = 20;
    end
    t = 0;
    while (done_seen == d0 && t < 6000) begin
      step(1);
      t++;
    end
    check("run_done_seen", done_seen, d0 + 1);
    step(3);
    check("single_done", done_seen, d0 + 1);
    flush();
  endtask

  initial begin
    reset = 1;
    run_go = 0;
    {cfg_stride, cfg_filter_size, cfg_if_words, cfg_flt_words, cfg_res_words} = '0;
    step(3);
    check_reset_outputs();
    reset = 0;
    step(2);
    run(16, 16, 16, 0, 0);
    cur_stride = 4;
    run(0, 0, 0, 0, 0);
    check("zero_targets_latency", done_cyc - go_cyc, 3);
    run(16, 16, 16, 0, 1);
    run(16, 16, 16, 0, 2);
    run(16, 16, 16, 0, 3);
    run(16, 16, 16, 0, 0);
    {rnd_if, rnd_flt, rnd_res, rnd_src} = 4'hf;
    for (int k = 0; k < 8; k++)
      run($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20), 0, 0);
    run(0, 12, 0, 0, 0);
    run(20, 0, 20, 0, 2);
`ifdef RUN_SEQ_TIMEOUT_EN
    {rnd_if, rnd_flt, rnd_res, rnd_src} = '0;
    flt_stuck = 1;
    run(2, 2, 0, 1, 0);
    check("timeout_latency", done_cyc - go_cyc >= (1 << TW), 1);
    flt_stuck = 0;
    run(3, 3, 3, 0, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
